network_mul_share_arb: RTL and testbench

- Shares one pipelined signed-16 x unsigned-13 multiplier (29-bit product, 2-cycle issue-to-result latency, clock-enable stall) among NUM_REQ requesters.
- Arbitrates valid/ready requests, issues at most one multiply per cycle, and carries the requester id alongside the datapath.
- Returns each product with its id on a single valid/ready result port.
- Sits between the conv/pool engines and the shared DSP multiplier in the network datapath.

---
 rtl/network_mul_share_arb.sv | 102 ++++++++++
 tb/tb_network_mul_share_arb.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/network_mul_share_arb.sv
// Shares one pipelined signed x unsigned multiplier among NUM_REQ requesters (2-stage, ce stall).
// Define MUL_SHARE_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module network_mul_share_arb #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int A_W     = 16,
  parameter int B_W     = 13,
  parameter int P_W     = A_W + B_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*A_W-1:0]   req_a,
  input  logic [NUM_REQ*B_W-1:0]   req_b,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [P_W-1:0]           res_data,
  output logic [ID_W-1:0]          res_id,
  output logic                     busy
);

  logic [NUM_REQ-1:0][A_W-1:0] a_arr;
  logic [NUM_REQ-1:0][B_W-1:0] b_arr;
  logic                        ce, issue, v1, v2;
  logic [ID_W-1:0]             grant, id1, id2;
  logic [A_W-1:0]              a_reg;
  logic [B_W-1:0]              b_reg;
  logic [P_W-1:0]              p_reg;
  logic signed [P_W-1:0]       a_ext, b_ext, prod;

  assign a_arr = req_a;
  assign b_arr = req_b;

`ifdef MUL_SHARE_FIXED_PRIO_EN
  always_comb begin
    grant = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (req_valid[i]) grant = ID_W'(i);
  end
`else
  logic [2:0]         rr_ptr;
  logic [NUM_REQ-1:0] rot;
  logic [3:0]         sum;

  // Rotate so bit j is requester (rr_ptr + j) mod NUM_REQ; first set bit wins.
  assign rot = NUM_REQ'({req_valid, req_valid} >> rr_ptr);

  always_comb begin
    sum = {1'b0, rr_ptr};
    for (int j = NUM_REQ - 1; j >= 0; j--)
      if (rot[j]) sum = {1'b0, rr_ptr} + 4'(j);
    if (sum >= 4'(NUM_REQ)) sum = sum - 4'(NUM_REQ);
    grant = ID_W'(sum);
  end

  always_ff @(posedge clk) begin
    if (!reset)     rr_ptr <= 3'd0;
    else if (issue) rr_ptr <= (int'(grant) == NUM_REQ - 1) ? 3'd0 : 3'(grant) + 3'd1;
  end
`endif

  assign ce    = ~v2 | res_ready;
  assign issue = reset & ce & (|req_valid);

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_rdy
    assign req_ready[i] = issue & (grant == ID_W'(i));
  end

  // B is unsigned: zero-extend so the product keeps its full signed range.
  assign a_ext = {{(P_W-A_W){a_reg[A_W-1]}}, a_reg};
  assign b_ext = {{(P_W-B_W){1'b0}}, b_reg};
  assign prod  = a_ext * b_ext;

  always_ff @(posedge clk) begin
    if (!reset) begin
      v1    <= 1'b0;
      v2    <= 1'b0;
      id1   <= '0;
      id2   <= '0;
      a_reg <= '0;
      b_reg <= '0;
      p_reg <= '0;
    end else if (ce) begin
      v1 <= issue;
      if (issue) begin
        id1   <= grant;
        a_reg <= a_arr[grant];
        b_reg <= b_arr[grant];
      end
      v2    <= v1;
      id2   <= id1;
      p_reg <= prod;
    end
  end

  assign res_valid = v2;
  assign res_data  = p_reg;
  assign res_id    = id2;
  assign busy      = v1 | v2;

endmodule

// File: tb/tb_network_mul_share_arb.sv
// Random + directed bench for network_mul_share_arb against a transaction-level reference model.
module tb_network_mul_share_arb;
  localparam int N = 4, AW = 16, BW = 13, PW = 29, IW = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req_valid, req_ready;
  logic [N*AW-1:0]   req_a;
  logic [N*BW-1:0]   req_b;
  logic              res_valid, res_ready, busy;
  logic [PW-1:0]     res_data;
  logic [IW-1:0]     res_id;

  logic signed [AW-1:0] ta [N];
  logic [BW-1:0]        tb_ [N];

  int errors = 0, checks = 0;

  // reference model state: one entry per pipeline slot, values as plain integers
  bit     m_v1, m_v2;
  longint m_p1, m_p2;
  int     m_id1, m_id2, m_ptr;
  logic [N-1:0] rdy_log [$];

  network_mul_share_arb dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_id(res_id), .busy(busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < N; i++) begin
      req_a[i*AW +: AW] = ta[i];
      req_b[i*BW +: BW] = tb_[i];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int mgrant(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic logic [63:0] sx(input logic [PW-1:0] d);
    return {{(64-PW){d[PW-1]}}, d};
  endfunction

  // check outputs mid-cycle, then advance the model across the rising edge
  task automatic cycle();
    logic [N-1:0] er;
    bit ce, iss;
    int g;
    @(negedge clk);
    ce  = !m_v2 || res_ready;
    g   = mgrant(req_valid, m_ptr);
    iss = reset && ce && (g >= 0);
    er  = '0;
    if (iss) er[g] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(er));
    chk("res_valid", 64'(res_valid), 64'(m_v2));
    chk("busy", 64'(busy), 64'(m_v1 | m_v2));
    if (m_v2) begin
      chk("res_data", sx(res_data), m_p2);
      chk("res_id", 64'(res_id), 64'(m_id2));
    end
    rdy_log.push_back(req_ready);
    @(posedge clk);
    if (!reset) begin
      m_v1 = 0; m_v2 = 0; m_ptr = 0;
    end else if (ce) begin
      m_v2 = m_v1; m_p2 = m_p1; m_id2 = m_id1;
      m_v1 = iss;
      if (iss) begin
        m_p1  = longint'(ta[g]) * longint'(tb_[g]);
        m_id1 = g;
`ifndef MUL_SHARE_FIXED_PRIO_EN
        m_ptr = (g + 1) % N;
`endif
      end
    end
    #1;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      ta[i]  = AW'($urandom);
      tb_[i] = BW'($urandom);
    end
  endtask

  initial begin
    m_v1 = 0; m_v2 = 0; m_p1 = 0; m_p2 = 0; m_id1 = 0; m_id2 = 0; m_ptr = 0;
    reset = 1'b0; req_valid = '0; res_ready = 1'b1;
    rand_ops();
    #1;
    // reset state
    cycle(); cycle();
    chk("rst_res_data", 64'(res_data), 64'd0);
    chk("rst_res_id", 64'(res_id), 64'd0);
    reset = 1'b1;

    // single request from requester 2
    ta[2] = -16'sd3; tb_[2] = 13'd4095; req_valid = 4'b0100;
    cycle();
    req_valid = '0;
    cycle();
    chk("single_valid", 64'(res_valid), 64'd1);
    chk("single_data", 64'(res_data), 64'h1FFFD003);
    chk("single_id", 64'(res_id), 64'd2);
    cycle();
    chk("single_busy", 64'(busy), 64'd0);

    // all requesters valid from reset: grant rotation
    reset = 1'b0; cycle(); reset = 1'b1;
    req_valid = 4'hF;
    rdy_log.delete();
    for (int k = 0; k < 6; k++) begin rand_ops(); cycle(); end
    for (int k = 0; k < 6; k++) begin
`ifdef MUL_SHARE_FIXED_PRIO_EN
      chk("rr_order", 64'(rdy_log[k]), 64'd1);
`else
      chk("rr_order", 64'(rdy_log[k]), 64'(1 << (k % N)));
`endif
    end
    req_valid = '0;
    cycle(); cycle(); cycle();

    // extreme operands
    ta[0] = -16'sd32768; tb_[0] = 13'd8191; req_valid = 4'b0001;
    cycle();
    ta[0] = 16'sd32767;
    cycle();
    req_valid = '0;
    chk("ext_neg", 64'(res_data), 64'h10008000);
    cycle();
    chk("ext_pos", 64'(res_data), 64'h0FFF6001);
    cycle(); cycle();

    // backpressure with an entry parked in each stage
    rand_ops(); req_valid = 4'b0001;
    cycle();
    req_valid = 4'b0010;
    cycle();
    res_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("bp_id", 64'(res_id), 64'd0);
      chk("bp_ready", 64'(req_ready), 64'd0);
    end
    res_ready = 1'b1; req_valid = '0;
    cycle();
    chk("bp_next_id", 64'(res_id), 64'd1);
    chk("bp_next_valid", 64'(res_valid), 64'd1);
    cycle(); cycle();

    // reset mid-stream
    req_valid = 4'hF;
    cycle(); cycle();
    reset = 1'b0;
    cycle();
    chk("mrst_valid", 64'(res_valid), 64'd0);
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_data", 64'(res_data), 64'd0);
    reset = 1'b1; req_valid = 4'b1010;
    rdy_log.delete();
    cycle();
    chk("mrst_first_grant", 64'(rdy_log[0]), 64'b0010);
    req_valid = '0;
    cycle(); cycle();

    // requesters 0 and 3 contending
    req_valid = 4'b1001;
    for (int k = 0; k < 6; k++) begin rand_ops(); cycle(); end
    req_valid = '0;
    cycle(); cycle();

    // randomized traffic with occasional stalls and resets
    for (int k = 0; k < 400; k++) begin
      rand_ops();
      req_valid = N'($urandom);
      res_ready = ($urandom_range(0, 9) < 7);
      reset     = ($urandom_range(0, 99) != 0);
      cycle();
    end
    reset = 1'b1; res_ready = 1'b1; req_valid = '0;
    cycle(); cycle(); cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
